// File: rtl/bus_arbiter_2m_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM encoding, master ids,
// request bundle and the round-robin pick helper.
package bus_arbiter_2m_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam logic        MASTER_CPU             = 1'b0;
  localparam logic        MASTER_DMA             = 1'b1;
  localparam logic [31:0] DEFAULT_TIMEOUT_RDATA  = 32'hDEAD_BEEF;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  // On a tie the master that was not served last wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    logic pick;
    if (req0 && req1) begin
      pick = ~last;
    end else if (req1) begin
      pick = MASTER_DMA;
    end else begin
      pick = MASTER_CPU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/bus_arbiter_2m_watchdog.sv
// Saturating busy-cycle watchdog: expire is high on the last allowed cycle while enabled.
// TIMEOUT_CYCLES = 0 builds no counter and never expires.
module bus_arbiter_2m_watchdog
  import bus_arbiter_2m_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int unsigned   TW   = $clog2(TIMEOUT_CYCLES) + 1;
      localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
      localparam logic [TW-1:0] SAT  = TW'(TIMEOUT_CYCLES);

      logic [TW-1:0] timer_r;

      // Count enabled cycles; hold at SAT so the counter can never wrap.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          timer_r <= {TW{1'b0}};
        end else if (clear) begin
          timer_r <= {TW{1'b0}};
        end else if (enable && (timer_r != SAT)) begin
          timer_r <= timer_r + TW'(1);
        end else begin
          timer_r <= timer_r;
        end
      end

      assign expire = enable && (timer_r == LAST);
    end
  endgenerate

endmodule

// File: rtl/bus_arbiter_2m.sv
// Round-robin arbiter sharing one slave bus between the CPU (m0) and a DMA/debug
// master (m1); a watchdog turns a hung slave into an error completion with IRQ.
module bus_arbiter_2m
  import bus_arbiter_2m_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [31:0] TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        owner,
  input  logic        err_clear,
  output logic        err_flag,
  output logic [31:0] err_addr,
  output logic        irq_timeout
);

  arb_state_e  state_r;
  logic        owner_r;
  logic        last_r;
  logic        err_flag_r;
  logic [31:0] err_addr_r;

  bus_req_t    m0_req_s;
  bus_req_t    m1_req_s;
  bus_req_t    own_req_s;
  logic        busy_s;
  logic        expire_s;
  logic        done_ok_s;
  logic        timeout_s;
  logic        ready_s;
  logic [31:0] rdata_s;

  assign m0_req_s = {m0_valid, m0_addr, m0_wdata, m0_wstrb};
  assign m1_req_s = {m1_valid, m1_addr, m1_wdata, m1_wstrb};

  // Owner mux and completion decode; reset_n gates everything so a reset mid-transaction emits nothing.
  always_comb begin
    own_req_s = m0_req_s;
    if (owner_r == MASTER_DMA) begin
      own_req_s = m1_req_s;
    end else begin
      own_req_s = m0_req_s;
    end
    busy_s    = reset_n && (state_r == ARB_BUSY);
    done_ok_s = busy_s && own_req_s.valid && s_ready;
    timeout_s = busy_s && own_req_s.valid && !s_ready && expire_s;
    ready_s   = done_ok_s || timeout_s;
    rdata_s   = 32'h0000_0000;
    if (timeout_s) begin
      rdata_s = TIMEOUT_RDATA;
    end else if (done_ok_s) begin
      rdata_s = s_rdata;
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // A forced completion drops s_valid so a stuck write never reaches the slave.
  assign s_valid     = busy_s && own_req_s.valid && !timeout_s;
  assign s_addr      = own_req_s.addr;
  assign s_wdata     = own_req_s.wdata;
  assign s_wstrb     = own_req_s.wstrb;

  assign m0_ready    = ready_s && (owner_r == MASTER_CPU);
  assign m1_ready    = ready_s && (owner_r == MASTER_DMA);
  assign m0_rdata    = m0_ready ? rdata_s : 32'h0000_0000;
  assign m1_rdata    = m1_ready ? rdata_s : 32'h0000_0000;

  assign owner       = owner_r;
  assign err_flag    = err_flag_r;
  assign err_addr    = err_addr_r;
  assign irq_timeout = err_flag_r;

  bus_arbiter_2m_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (state_r != ARB_BUSY),
    .enable (state_r == ARB_BUSY),
    .expire (expire_s)
  );

  // Arbitration FSM: grant is registered in IDLE and held until completion or abort.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ARB_IDLE;
      owner_r <= MASTER_CPU;
      last_r  <= MASTER_DMA;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (m0_valid || m1_valid) begin
            owner_r <= rr_pick(m0_valid, m1_valid, last_r);
            state_r <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (!own_req_s.valid) begin
            state_r <= ARB_IDLE;
          end else if (ready_s) begin
            last_r  <= owner_r;
            state_r <= ARB_IDLE;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  // Sticky error capture; a new timeout beats err_clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_flag_r <= 1'b0;
      err_addr_r <= 32'h0000_0000;
    end else if (timeout_s) begin
      err_flag_r <= 1'b1;
      if (!err_flag_r || err_clear) begin
        err_addr_r <= own_req_s.addr;
      end
    end else if (err_clear) begin
      err_flag_r <= 1'b0;
      err_addr_r <= 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Directed scenarios followed by random traffic, all checked cycle by cycle
// against a transaction-level model of the arbiter.
module tb_bus_arbiter_2m;

  localparam int TMO = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, err_clear;
  logic        m0_valid, m1_valid, m0_ready, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, m0_rdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic        s_valid, s_ready, owner, err_flag, irq_timeout;
  logic [31:0] s_addr, s_wdata, s_rdata, err_addr;

  bus_arbiter_2m #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .owner(owner), .err_clear(err_clear), .err_flag(err_flag), .err_addr(err_addr),
    .irq_timeout(irq_timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: m_cur = master being served (-1 none), m_timer = cycles spent on it so far.
  int          m_cur, m_owner, m_last, m_timer;
  logic        m_err;
  logic [31:0] m_err_addr;

  // Slave behaviour: >=0 ready at that served cycle, -1 never, -2 random, -3 always.
  int          slave_lat;
  logic        fix_en;
  logic [31:0] fix_rdata;

  logic        e_rdy0, e_rdy1, d_rdy0, d_rdy1;
  logic [31:0] d_rd0, d_rd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = -1; m_owner = 0; m_last = 1; m_timer = 0;
    m_err = 1'b0; m_err_addr = 32'h0;
  endtask

  task automatic cycle();
    logic [1:0]  v;
    logic        ov, ok, to;
    logic [31:0] ex_rd, own_addr, own_wdata;
    logic [3:0]  own_wstrb;
    if (slave_lat == -2)      s_ready = ($urandom_range(0, 99) < 35);
    else if (slave_lat == -3) s_ready = 1'b1;
    else                      s_ready = (m_cur >= 0) && (slave_lat >= 0) && (m_timer == slave_lat);
    s_rdata = fix_en ? fix_rdata : $urandom();
    #4;
    v = {m1_valid, m0_valid};
    ov = 1'b0; own_addr = 32'h0; own_wdata = 32'h0; own_wstrb = 4'h0;
    if (m_cur >= 0) begin
      own_addr  = (m_cur == 1) ? m1_addr  : m0_addr;
      own_wdata = (m_cur == 1) ? m1_wdata : m0_wdata;
      own_wstrb = (m_cur == 1) ? m1_wstrb : m0_wstrb;
      if (reset_n) ov = v[m_cur];
    end
    ok = ov && s_ready;
    to = ov && !s_ready && (m_timer == TMO - 1);
    ex_rd  = ok ? s_rdata : (to ? 32'hDEAD_BEEF : 32'h0);
    e_rdy0 = (ok || to) && (m_cur == 0);
    e_rdy1 = (ok || to) && (m_cur == 1);
    d_rdy0 = m0_ready; d_rdy1 = m1_ready; d_rd0 = m0_rdata; d_rd1 = m1_rdata;
    chk("s_valid", 32'(s_valid), 32'(ov && !to));
    if (ov && !to) begin
      chk("s_addr", s_addr, own_addr);
      chk("s_wdata", s_wdata, own_wdata);
      chk("s_wstrb", 32'(s_wstrb), 32'(own_wstrb));
    end
    chk("m0_ready", 32'(m0_ready), 32'(e_rdy0));
    chk("m1_ready", 32'(m1_ready), 32'(e_rdy1));
    chk("m0_rdata", m0_rdata, e_rdy0 ? ex_rd : 32'h0);
    chk("m1_rdata", m1_rdata, e_rdy1 ? ex_rd : 32'h0);
    chk("owner", 32'(owner), 32'(m_owner));
    chk("err_flag", 32'(err_flag), 32'(m_err));
    chk("irq_timeout", 32'(irq_timeout), 32'(m_err));
    chk("err_addr", err_addr, m_err_addr);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (to) begin
        if (!m_err || err_clear) m_err_addr = own_addr;
        m_err = 1'b1;
      end else if (err_clear) begin
        m_err = 1'b0; m_err_addr = 32'h0;
      end
      if (m_cur < 0) begin
        if (v != 2'b00) begin
          m_cur   = (v == 2'b11) ? (1 - m_last) : (v[1] ? 1 : 0);
          m_owner = m_cur;
          m_timer = 0;
        end
      end else if (!ov) begin
        m_cur = -1;
      end else if (ok || to) begin
        m_last = m_cur; m_cur = -1;
      end else begin
        m_timer++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, k, cnt0, cnt1;
    reset_n = 1'b0; err_clear = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
    m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    slave_lat = -1; fix_en = 1'b0; fix_rdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cycle();
    reset_n = 1'b1;
    cycle();

    // m0 read, slave answers on the 4th served cycle
    m0_valid = 1'b1; m0_addr = 32'h0002_0000; m0_wstrb = 4'h0;
    slave_lat = 3; fix_en = 1'b1; fix_rdata = 32'h1234_5678;
    n = 0;
    while (n < 20) begin cycle(); n++; if (d_rdy0) break; end
    chk("t1_latency", 32'(n), 32'd5);
    chk("t1_rdata", d_rd0, 32'h1234_5678);
    chk("t1_m1_ready", 32'(d_rdy1), 32'd0);
    m0_valid = 1'b0; fix_en = 1'b0;
    cycle();

    // Tie from reset: alternating grants starting with m0
    reset_n = 1'b0; cycle(); reset_n = 1'b1;
    slave_lat = 1; cnt0 = 0; cnt1 = 0; k = 0;
    m0_valid = 1'b1; m0_addr = 32'h0000_1000; m0_wdata = 32'hA0A0_0000; m0_wstrb = 4'h3;
    m1_valid = 1'b1; m1_addr = 32'h4000_2000; m1_wdata = 32'hB0B0_0000; m1_wstrb = 4'hC;
    for (int c = 0; c < 200 && k < 8; c++) begin
      cycle();
      if (d_rdy0 || d_rdy1) begin
        chk("t2_grant", 32'(d_rdy1), 32'(k % 2));
        k++;
        if (d_rdy0) begin
          cnt0++;
          if (cnt0 < 4) m0_addr = 32'h0000_1000 + 32'(cnt0 * 4); else m0_valid = 1'b0;
        end
        if (d_rdy1) begin
          cnt1++;
          if (cnt1 < 4) m1_addr = 32'h4000_2000 + 32'(cnt1 * 4); else m1_valid = 1'b0;
        end
      end
    end
    chk("t2_count", 32'(k), 32'd8);
    cycle();

    // m1 write to a dead slave: two timeouts, then clear
    m1_valid = 1'b1; m1_addr = 32'h8000_0000; m1_wdata = $urandom(); m1_wstrb = 4'hF;
    slave_lat = -1;
    n = 0;
    while (n < 300) begin cycle(); n++; if (d_rdy1) break; end
    chk("t3_cycles", 32'(n), 32'd257);
    chk("t3_rdata", d_rd1, 32'hDEAD_BEEF);
    m1_valid = 1'b0;
    cycle();
    chk("t3_err_flag", 32'(err_flag), 32'd1);
    chk("t3_err_addr", err_addr, 32'h8000_0000);
    chk("t3_irq", 32'(irq_timeout), 32'd1);
    m1_valid = 1'b1; m1_addr = 32'h8000_0004;
    n = 0;
    while (n < 300) begin cycle(); n++; if (d_rdy1) break; end
    chk("t3b_cycles", 32'(n), 32'd257);
    m1_valid = 1'b0;
    cycle();
    chk("t3b_err_addr", err_addr, 32'h8000_0000);
    err_clear = 1'b1; cycle(); err_clear = 1'b0;
    chk("t3c_err_flag", 32'(err_flag), 32'd0);
    chk("t3c_err_addr", err_addr, 32'h0);
    chk("t3c_irq", 32'(irq_timeout), 32'd0);

    // Slave answers on the very last served cycle: normal completion
    m0_valid = 1'b1; m0_addr = 32'h0003_0010; m0_wstrb = 4'h0;
    slave_lat = TMO - 1; fix_en = 1'b1; fix_rdata = 32'h0BAD_CAFE;
    n = 0;
    while (n < 300) begin cycle(); n++; if (d_rdy0) break; end
    chk("t4_cycles", 32'(n), 32'd257);
    chk("t4_rdata", d_rd0, 32'h0BAD_CAFE);
    m0_valid = 1'b0; fix_en = 1'b0;
    cycle();
    chk("t4_err_flag", 32'(err_flag), 32'd0);

    // Reset while m1 is being served, slave claiming ready during reset
    m1_valid = 1'b1; m1_addr = 32'h1000_0000; slave_lat = -1;
    repeat (3) cycle();
    reset_n = 1'b0; slave_lat = -3;
    cycle();
    chk("t5_no_ready", 32'(d_rdy1), 32'd0);
    chk("t5_owner", 32'(owner), 32'd0);
    chk("t5_s_valid", 32'(s_valid), 32'd0);
    reset_n = 1'b1; slave_lat = 2;
    m0_valid = 1'b1; m0_addr = 32'h0000_2000;
    n = 0;
    while (n < 20) begin cycle(); n++; if (d_rdy0 || d_rdy1) break; end
    chk("t5_first_m0", 32'(d_rdy0), 32'd1);
    m0_valid = 1'b0;
    n = 0;
    while (n < 20) begin cycle(); n++; if (d_rdy1) break; end
    chk("t5_then_m1", 32'(d_rdy1), 32'd1);
    m1_valid = 1'b0;
    cycle();

    // Owner aborts; pending master is served next
    m0_valid = 1'b1; m0_addr = 32'h0000_3000; slave_lat = -1;
    cycle(); cycle();
    m1_valid = 1'b1; m1_addr = 32'h2000_0000;
    cycle();
    m0_valid = 1'b0;
    cycle();
    chk("t6_no_ready", 32'(d_rdy0), 32'd0);
    slave_lat = 1;
    n = 0;
    while (n < 20) begin cycle(); n++; if (d_rdy1) break; end
    chk("t6_latency", 32'(n), 32'd3);
    m1_valid = 1'b0;
    cycle();

    // Random traffic
    slave_lat = -2;
    for (int c = 0; c < 3000; c++) begin
      err_clear = ($urandom_range(0, 49) == 0);
      cycle();
      if (m0_valid) begin
        if (e_rdy0 || $urandom_range(0, 99) == 0) m0_valid = 1'b0;
      end else if ($urandom_range(0, 99) < 30) begin
        m0_valid = 1'b1; m0_addr = $urandom(); m0_wdata = $urandom();
        m0_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom());
      end
      if (m1_valid) begin
        if (e_rdy1 || $urandom_range(0, 99) == 0) m1_valid = 1'b0;
      end else if ($urandom_range(0, 99) < 30) begin
        m1_valid = 1'b1; m1_addr = $urandom(); m1_wdata = $urandom();
        m1_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
